// File: rtl/rst_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rst_interrupt_sequencer
// Brief    : XPT timing-state counter plus interrupt latch/arbiter that
//            injects RST opcodes into the Source bus at instruction boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module rst_interrupt_sequencer #(
  parameter int unsigned XPT_W   = 5,
  parameter int unsigned XPT_MAX = 31
) (
  input  logic             clock,
  input  logic             notReset,
  input  logic             enable,
  input  logic             wait_req,
  input  logic             reset_xpt,
  input  logic             ei,
  input  logic             di,
  input  logic [7:0]       irq,
  input  logic [7:0]       irq_mask,
  input  logic [7:0]       fetched_op,
  output logic [XPT_W-1:0] XPT,
  output logic [XPT_W-1:0] notXPT,
  output logic [7:0]       Source,
  output logic [7:0]       notSource,
  output logic             inject_active,
  output logic             inhibit_pc_inc,
  output logic             int_ack,
  output logic [2:0]       int_vector,
  output logic             ie,
  output logic [7:0]       pending,
  output logic             xpt_stuck
);

  localparam logic [0:0]       c_ST_NORMAL = 1'b0;
  localparam logic [0:0]       c_ST_INJECT = 1'b1;
  localparam logic [XPT_W-1:0] c_XPT_MAX   = XPT_W'(XPT_MAX);
  localparam logic [XPT_W-1:0] c_XPT_PRE   = XPT_W'(XPT_MAX - 1);
  localparam logic [XPT_W-1:0] c_XPT_FETCH = XPT_W'(3);

  logic [XPT_W-1:0] r_xpt;
  logic [0:0]       r_state;
  logic             r_ie;
  logic [7:0]       r_pending;
  logic [7:0]       r_irq_prev;
  logic [2:0]       r_vec;
  logic             r_int_ack;
  logic             r_xpt_stuck;

  logic             w_step;
  logic             w_boundary;
  logic [7:0]       w_req;
  logic [7:0]       w_rise;
  logic [7:0]       w_clr;
  logic [2:0]       w_sel;
  logic             w_accept;

  assign w_step     = enable & ~wait_req;
  assign w_boundary = w_step & reset_xpt;
  assign w_rise     = irq & ~r_irq_prev;
  assign w_req      = r_pending & irq_mask;
  assign w_accept   = w_boundary & r_ie & (|w_req);

  // Scan downward so the lowest set index is the one left in w_sel
  always_comb begin
    w_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_req[i]) begin
        w_sel = 3'(i);
      end
    end
  end

  always_comb begin
    w_clr = 8'h00;
    if (w_accept) begin
      w_clr[w_sel] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      r_xpt       <= '0;
      r_xpt_stuck <= 1'b0;
    end else if (w_boundary) begin
      r_xpt <= '0;
    end else if (w_step) begin
      if (r_xpt != c_XPT_MAX) begin
        r_xpt <= r_xpt + 1'b1;
      end
      if (r_xpt >= c_XPT_PRE) begin
        r_xpt_stuck <= 1'b1;
      end
    end
  end

  // A rising edge in the same cycle as the ack clear keeps the bit set
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      r_irq_prev <= 8'h00;
      r_pending  <= 8'h00;
    end else begin
      r_irq_prev <= irq;
      r_pending  <= (r_pending & ~w_clr) | w_rise;
    end
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      r_ie <= 1'b0;
    end else if (di || w_accept) begin
      r_ie <= 1'b0;
    end else if (ei) begin
      r_ie <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      r_state   <= c_ST_NORMAL;
      r_vec     <= 3'd0;
      r_int_ack <= 1'b0;
    end else begin
      r_int_ack <= w_accept;
      if (w_accept) begin
        r_vec <= w_sel;
      end
      if (w_boundary) begin
        r_state <= w_accept ? c_ST_INJECT : c_ST_NORMAL;
      end
    end
  end

  assign XPT            = r_xpt;
  assign notXPT         = ~r_xpt;
  assign inject_active  = (r_state == c_ST_INJECT);
  assign Source         = inject_active ? {2'b11, r_vec, 3'b111} : fetched_op;
  assign notSource      = ~Source;
  assign inhibit_pc_inc = inject_active & (r_xpt <= c_XPT_FETCH);
  assign int_ack        = r_int_ack;
  assign int_vector     = r_vec;
  assign ie             = r_ie;
  assign pending        = r_pending;
  assign xpt_stuck      = r_xpt_stuck;

endmodule
`default_nettype wire

// File: tb/tb_rst_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_interrupt_sequencer
// Brief    : Directed self-checking bench for rst_interrupt_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_interrupt_sequencer;

  logic       clock = 1'b0;
  logic       notReset;
  logic       enable, wait_req, reset_xpt, ei, di;
  logic [7:0] irq, irq_mask, fetched_op;
  logic [4:0] XPT, notXPT;
  logic [7:0] Source, notSource, pending;
  logic       inject_active, inhibit_pc_inc, int_ack, ie, xpt_stuck;
  logic [2:0] int_vector;

  int n_checks = 0;
  int n_fail   = 0;

  rst_interrupt_sequencer #(.XPT_W(5), .XPT_MAX(31)) dut (
    .clock(clock), .notReset(notReset), .enable(enable), .wait_req(wait_req),
    .reset_xpt(reset_xpt), .ei(ei), .di(di), .irq(irq), .irq_mask(irq_mask),
    .fetched_op(fetched_op), .XPT(XPT), .notXPT(notXPT), .Source(Source),
    .notSource(notSource), .inject_active(inject_active),
    .inhibit_pc_inc(inhibit_pc_inc), .int_ack(int_ack), .int_vector(int_vector),
    .ie(ie), .pending(pending), .xpt_stuck(xpt_stuck)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic boundary();
    reset_xpt = 1'b1;
    tick();
    reset_xpt = 1'b0;
  endtask

  task automatic test_reset();
    notReset = 1'b0; enable = 1'b0; wait_req = 1'b0; reset_xpt = 1'b0;
    ei = 1'b0; di = 1'b0; irq = 8'h00; irq_mask = 8'hFF; fetched_op = 8'h3C;
    tick(); tick();
    n_checks++; if (XPT !== 5'd0 || notXPT !== 5'h1F) begin n_fail++; $display("FAIL reset_xpt XPT=%0d notXPT=%h exp 0/1f", XPT, notXPT); end
    n_checks++; if (Source !== 8'h3C || notSource !== 8'hC3) begin n_fail++; $display("FAIL reset_source Source=%h notSource=%h exp 3c/c3", Source, notSource); end
    n_checks++; if ({ie, int_ack, inject_active, inhibit_pc_inc, xpt_stuck} !== 5'b0 || pending !== 8'h00) begin n_fail++; $display("FAIL reset_flags flags=%b pending=%h exp 00000/00", {ie, int_ack, inject_active, inhibit_pc_inc, xpt_stuck}, pending); end
    notReset = 1'b1;
    tick();
  endtask

  task automatic test_xpt_count();
    enable = 1'b1;
    n_checks++; if (XPT !== 5'd0) begin n_fail++; $display("FAIL count_start XPT=%0d exp 0", XPT); end
    for (int k = 1; k <= 40; k++) begin
      tick();
      n_checks++;
      if (XPT !== ((k > 31) ? 5'd31 : 5'(k)) || xpt_stuck !== (k >= 31)) begin
        n_fail++; $display("FAIL count_k%0d XPT=%0d stuck=%b exp %0d/%b", k, XPT, xpt_stuck, (k > 31) ? 31 : k, k >= 31);
      end
    end
    boundary();
    n_checks++; if (XPT !== 5'd0 || xpt_stuck !== 1'b1) begin n_fail++; $display("FAIL count_clear XPT=%0d stuck=%b exp 0/1", XPT, xpt_stuck); end
  endtask

  task automatic test_wait();
    for (int k = 0; k < 10; k++) tick();
    n_checks++; if (XPT !== 5'd10) begin n_fail++; $display("FAIL wait_pre XPT=%0d exp 10", XPT); end
    wait_req = 1'b1; reset_xpt = 1'b1;
    tick(); tick();
    n_checks++; if (XPT !== 5'd10) begin n_fail++; $display("FAIL wait_hold XPT=%0d exp 10", XPT); end
    wait_req = 1'b0; enable = 1'b0;
    tick();
    n_checks++; if (XPT !== 5'd10) begin n_fail++; $display("FAIL disabled_hold XPT=%0d exp 10", XPT); end
    enable = 1'b1;
    tick();
    reset_xpt = 1'b0;
    n_checks++; if (XPT !== 5'd0) begin n_fail++; $display("FAIL wait_release XPT=%0d exp 0", XPT); end
  endtask

  task automatic test_single_irq();
    ei = 1'b1; tick(); ei = 1'b0;
    n_checks++; if (ie !== 1'b1) begin n_fail++; $display("FAIL ei_set ie=%b exp 1", ie); end
    irq = 8'h08; tick();
    n_checks++; if (pending !== 8'h08) begin n_fail++; $display("FAIL irq3_latch pending=%h exp 08", pending); end
    tick(); tick();
    boundary();
    n_checks++; if (int_ack !== 1'b1 || int_vector !== 3'd3) begin n_fail++; $display("FAIL irq3_ack ack=%b vec=%0d exp 1/3", int_ack, int_vector); end
    n_checks++; if (Source !== 8'hDF || notSource !== 8'h20 || inject_active !== 1'b1) begin n_fail++; $display("FAIL irq3_source Source=%h notSource=%h inj=%b exp df/20/1", Source, notSource, inject_active); end
    n_checks++; if (ie !== 1'b0 || pending !== 8'h00) begin n_fail++; $display("FAIL irq3_clear ie=%b pending=%h exp 0/00", ie, pending); end
    for (int t = 0; t <= 5; t++) begin
      n_checks++;
      if (XPT !== 5'(t) || inhibit_pc_inc !== (t <= 3)) begin n_fail++; $display("FAIL irq3_inhibit_t%0d XPT=%0d inh=%b exp %0d/%b", t, XPT, inhibit_pc_inc, t, t <= 3); end
      if (t == 1) begin
        n_checks++; if (int_ack !== 1'b0) begin n_fail++; $display("FAIL irq3_ack_pulse ack=%b exp 0", int_ack); end
      end
      tick();
    end
    irq = 8'h00;
    boundary();
    n_checks++; if (inject_active !== 1'b0 || Source !== 8'h3C || int_ack !== 1'b0) begin n_fail++; $display("FAIL irq3_exit inj=%b Source=%h ack=%b exp 0/3c/0", inject_active, Source, int_ack); end
  endtask

  task automatic test_priority();
    irq = 8'h22; tick();
    ei = 1'b1; tick(); ei = 1'b0;
    boundary();
    n_checks++; if (int_ack !== 1'b1 || int_vector !== 3'd1 || Source !== 8'hCF) begin n_fail++; $display("FAIL prio_first ack=%b vec=%0d Source=%h exp 1/1/cf", int_ack, int_vector, Source); end
    n_checks++; if (pending !== 8'h20 || ie !== 1'b0) begin n_fail++; $display("FAIL prio_pending pending=%h ie=%b exp 20/0", pending, ie); end
    tick();
    boundary();
    n_checks++; if (inject_active !== 1'b0 || int_ack !== 1'b0 || Source !== 8'h3C || pending !== 8'h20) begin n_fail++; $display("FAIL prio_noie inj=%b ack=%b Source=%h pending=%h exp 0/0/3c/20", inject_active, int_ack, Source, pending); end
    ei = 1'b1; tick(); ei = 1'b0;
    boundary();
    n_checks++; if (int_ack !== 1'b1 || int_vector !== 3'd5 || Source !== 8'hEF || pending !== 8'h00) begin n_fail++; $display("FAIL prio_second ack=%b vec=%0d Source=%h pending=%h exp 1/5/ef/00", int_ack, int_vector, Source, pending); end
    boundary();
    irq = 8'h00; tick();
  endtask

  task automatic test_mask();
    irq_mask = 8'hFE; irq = 8'h01; fetched_op = 8'h5A; tick();
    ei = 1'b1; tick(); ei = 1'b0;
    boundary();
    n_checks++; if (int_ack !== 1'b0 || inject_active !== 1'b0 || Source !== 8'h5A) begin n_fail++; $display("FAIL mask_block ack=%b inj=%b Source=%h exp 0/0/5a", int_ack, inject_active, Source); end
    n_checks++; if (pending !== 8'h01 || ie !== 1'b1) begin n_fail++; $display("FAIL mask_hold pending=%h ie=%b exp 01/1", pending, ie); end
    irq_mask = 8'hFF;
    boundary();
    n_checks++; if (int_ack !== 1'b1 || int_vector !== 3'd0 || Source !== 8'hC7) begin n_fail++; $display("FAIL mask_release ack=%b vec=%0d Source=%h exp 1/0/c7", int_ack, int_vector, Source); end
    boundary();
    irq = 8'h00; tick();
  endtask

  task automatic test_ei_di_and_abort();
    ei = 1'b1; tick(); ei = 1'b0;
    ei = 1'b1; di = 1'b1; tick(); ei = 1'b0; di = 1'b0;
    n_checks++; if (ie !== 1'b0) begin n_fail++; $display("FAIL ei_di ie=%b exp 0", ie); end
    ei = 1'b1; tick(); ei = 1'b0;
    irq = 8'h10; tick();
    boundary();
    tick();
    n_checks++; if (inject_active !== 1'b1 || Source !== 8'hE7 || XPT !== 5'd1) begin n_fail++; $display("FAIL abort_pre inj=%b Source=%h XPT=%0d exp 1/e7/1", inject_active, Source, XPT); end
    notReset = 1'b0;
    #1;
    n_checks++; if (inject_active !== 1'b0 || Source !== 8'h5A || XPT !== 5'd0 || inhibit_pc_inc !== 1'b0) begin n_fail++; $display("FAIL abort_async inj=%b Source=%h XPT=%0d inh=%b exp 0/5a/0/0", inject_active, Source, XPT, inhibit_pc_inc); end
    n_checks++; if ({ie, int_ack, xpt_stuck} !== 3'b000 || pending !== 8'h00 || int_vector !== 3'd0) begin n_fail++; $display("FAIL abort_flags flags=%b pending=%h vec=%0d exp 000/00/0", {ie, int_ack, xpt_stuck}, pending, int_vector); end
    irq = 8'h00;
    tick();
    notReset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_xpt_count();
    test_wait();
    test_single_irq();
    test_priority();
    test_mask();
    test_ei_di_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
